// File: rtl/seg7_pkg.sv
// Shared glyph data for the seven-segment counter: hex glyph table in
// active-high {g,f,e,d,c,b,a} form, the blank pattern and a lookup helper.
package seg7_pkg;

   typedef logic [6:0] seg_t;

   // All segments dark (active-high form).
   localparam seg_t SEG_BLANK = 7'h00;

   // Hex glyphs 0..F, active-high, bit order {g,f,e,d,c,b,a}.
   localparam seg_t SEG_GLYPHS [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic seg_t seg7_glyph(input logic [3:0] nibble);
      return SEG_GLYPHS[nibble];
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder; output is always active-high,
// the top level applies board polarity.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic       [3:0] nibble,
   input  logic             blank,
   output logic       [6:0] glyph
);

   // Blank overrides the glyph lookup.
   always_comb begin
      glyph = seg7_glyph(nibble);
      if (blank) begin
         glyph = SEG_BLANK;
      end
   end

endmodule

// File: rtl/seg7_mux_counter.sv
// Multi-digit hex up/down counter with a step prescaler and a multiplexed
// seven-segment display driver (registered segment/dp/digit outputs).
module seg7_mux_counter
   import seg7_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int TICK_DIV       = 50000000,
   parameter int SCAN_DIV       = 50000,
   parameter int SEG_ACTIVE_LOW = 1
)
(
   input  logic                  clockIn,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  up_n_down,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   input  logic                  blank_lz,
   output logic [4*DIGITS-1:0]   count_out,
   output logic                  tick,
   output logic [6:0]            segment7,
   output logic                  dp,
   output logic [DIGITS-1:0]     digit_en
);

   localparam int CNT_W  = 4 * DIGITS;
   localparam int PRE_W  = $clog2(TICK_DIV);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [PRE_W-1:0]  PRE_HALF  = PRE_W'(TICK_DIV / 2);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

   // Polarity: XOR an active-high value with ACT_LOW to get the pin level.
   localparam logic              ACT_LOW   = (SEG_ACTIVE_LOW != 0);
   localparam logic [6:0]        SEG_OFF   = {7{ACT_LOW}};
   localparam logic [DIGITS-1:0] EN_OFF    = {DIGITS{ACT_LOW}};

   logic [CNT_W-1:0]  count_q,    count_d;
   logic [PRE_W-1:0]  presc_q,    presc_d;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
   logic [6:0]        seg_q,      seg_d;
   logic              dp_q,       dp_d;
   logic [DIGITS-1:0] en_q,       en_d;

   logic              tick_now;
   logic [3:0]        nibbles [DIGITS];
   logic [DIGITS-1:0] lz_blank;
   logic [3:0]        sel_nibble;
   logic              sel_blank;
   logic [6:0]        sel_glyph;

   assign tick_now  = (presc_q == PRE_LAST);
   assign tick      = tick_now;
   assign count_out = count_q;
   assign segment7  = seg_q;
   assign dp        = dp_q;
   assign digit_en  = en_q;

   // Per-digit nibble split and leading-zero detection; digit 0 never blanks.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign nibbles[gi] = count_q[4*gi +: 4];
         if (gi == 0) begin : g_lsd
            assign lz_blank[gi] = 1'b0;
         end else begin : g_upper
            assign lz_blank[gi] = blank_lz & (count_q[CNT_W-1:4*gi] == '0);
         end
      end
   endgenerate

   assign sel_nibble = nibbles[scan_idx_q];
   assign sel_blank  = lz_blank[scan_idx_q];

   seg7_decode u_decode (
      .nibble (sel_nibble),
      .blank  (sel_blank),
      .glyph  (sel_glyph)
   );

   // Next-state: prescaler, counter step/load, scan slot/index, display image.
   always_comb begin
      presc_d    = tick_now ? '0 : presc_q + PRE_W'(1);
      count_d    = count_q;
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      scan_idx_d = scan_idx_q;

      if (load) begin
         count_d = load_value;
         presc_d = '0;
      end else if (tick_now && run) begin
         count_d = up_n_down ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
      end

      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
      end

      seg_d = sel_glyph ^ SEG_OFF;
      dp_d  = ((scan_idx_q == '0) && (presc_q < PRE_HALF)) ^ ACT_LOW;
      en_d  = (DIGITS'(1) << scan_idx_q) ^ EN_OFF;
   end

   // State and display registers; reset blanks the display and clears counts.
   always_ff @(posedge clockIn) begin
      if (reset) begin
         count_q    <= '0;
         presc_q    <= '0;
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
         seg_q      <= SEG_OFF;
         dp_q       <= ACT_LOW;
         en_q       <= EN_OFF;
      end else begin
         count_q    <= count_d;
         presc_q    <= presc_d;
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         en_q       <= en_d;
      end
   end

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Scoreboard bench for seg7_mux_counter: a behavioural model pushes the
// expected post-edge outputs each clock, a monitor pops and compares them.
module tb_seg7_mux_counter;

   localparam int DIGITS   = 4;
   localparam int TICK_DIV = 8;
   localparam int SCAN_DIV = 4;

   // Active-low hex glyphs {g,f,e,d,c,b,a} as seen on the board pins.
   localparam logic [6:0] GLYPH_AL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef struct packed {
      logic [15:0] count;
      logic        tick;
      logic [6:0]  seg;
      logic        dp;
      logic [3:0]  en;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, run, up_n_down, load, blank_lz;
   logic [15:0] load_value;
   logic [15:0] count_out;
   logic        tick;
   logic [6:0]  segment7;
   logic        dp;
   logic [3:0]  digit_en;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Model state: count value, prescaler position, clocks since reset.
   int m_count = 0;
   int m_pre   = 0;
   int m_scan  = 0;

   always #5 clk = ~clk;

   seg7_mux_counter #(
      .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1)
   ) dut (
      .clockIn(clk), .reset(reset), .run(run), .up_n_down(up_n_down),
      .load(load), .load_value(load_value), .blank_lz(blank_lz),
      .count_out(count_out), .tick(tick), .segment7(segment7), .dp(dp),
      .digit_en(digit_en)
   );

   // Reference model: evaluated at every rising edge with the inputs the DUT sees.
   initial begin : model
      exp_t e;
      int   dig;
      int   upper;
      bit   blank;
      bit   step;
      forever begin
         @(posedge clk);
         e = '0;
         if (reset) begin
            m_count = 0;
            m_pre   = 0;
            m_scan  = 0;
            e.seg   = 7'h7F;
            e.dp    = 1'b1;
            e.en    = 4'hF;
         end else begin
            dig   = (m_scan / SCAN_DIV) % DIGITS;
            upper = m_count >> (4 * dig);
            blank = blank_lz && (dig != 0) && (upper == 0);
            e.seg = blank ? 7'h7F : GLYPH_AL[upper % 16];
            e.dp  = !((dig == 0) && (m_pre < TICK_DIV / 2));
            e.en  = 4'hF & ~(4'h1 << dig);
            step  = (m_pre == TICK_DIV - 1) && run;
            if (load) begin
               m_count = int'(load_value);
               m_pre   = 0;
            end else begin
               if (step) m_count = up_n_down ? (m_count + 1) % 65536 : (m_count + 65535) % 65536;
               m_pre = (m_pre + 1) % TICK_DIV;
            end
            m_scan++;
         end
         e.count = 16'(m_count);
         e.tick  = (m_pre == TICK_DIV - 1);
         exp_q.push_back(e);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
   endtask

   // Monitor: compare the DUT outputs against the oldest expectation, away from the edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count_out", 32'(count_out), 32'(e.count));
            chk("tick",      32'(tick),      32'(e.tick));
            chk("segment7",  32'(segment7),  32'(e.seg));
            chk("dp",        32'(dp),        32'(e.dp));
            chk("digit_en",  32'(digit_en),  32'(e.en));
            if (e.tick) $display("tick: count_out=%h expected=%h", count_out, e.count);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [15:0] v);
      load_value = v;
      load       = 1'b1;
      cyc(1);
      load       = 1'b0;
   endtask

   initial begin : stimulus
      reset = 1'b1; run = 1'b0; up_n_down = 1'b1; load = 1'b0;
      load_value = '0; blank_lz = 1'b0;
      cyc(3);

      // Count up from reset: 0001 after first tick, 0003 after third.
      reset = 1'b0; run = 1'b1;
      cyc(30);

      // Wrap FFFF -> 0000 counting up.
      do_load(16'hFFFF);
      cyc(12);

      // Load coinciding with a tick edge must win over the step.
      for (int i = 0; i < TICK_DIV + 2; i++) begin
         if (m_pre == TICK_DIV - 1) break;
         cyc(1);
      end
      do_load(16'h1234);
      cyc(4);

      // Wrap 0000 -> FFFF counting down, then hold with run=0.
      up_n_down = 1'b0;
      do_load(16'h0000);
      cyc(12);
      run = 1'b0;
      cyc(3 * TICK_DIV + 2);

      // Display of 00A1 with and without leading-zero blanking.
      do_load(16'h00A1);
      blank_lz = 1'b1;
      cyc(20);
      blank_lz = 1'b0;
      cyc(20);

      // Reset in the middle of a scan slot.
      cyc(2);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      run = 1'b1; up_n_down = 1'b1;
      cyc(10);

      // Randomised phase.
      for (int i = 0; i < 800; i++) begin
         reset      = ($urandom_range(0, 99) == 0);
         load       = ($urandom_range(0, 15) == 0);
         load_value = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535))
                                                  : 16'($urandom_range(0, 300));
         if ($urandom_range(0, 7) == 0) run = ~run;
         if ($urandom_range(0, 15) == 0) up_n_down = ~up_n_down;
         if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
         cyc(1);
      end
      reset = 1'b0; load = 1'b0;
      cyc(3);
      @(negedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
